// File: rtl/wasca_perf_counter_pkg.sv
// Shared constants for the WASCA multi-section performance counter.
// Register offsets, status bit positions and the address-width helper.
package wasca_perf_counter_pkg;

  localparam logic [1:0] OFS_TIME_LO = 2'd0;
  localparam logic [1:0] OFS_TIME_HI = 2'd1;
  localparam logic [1:0] OFS_EVENT   = 2'd2;
  localparam logic [1:0] OFS_STATUS  = 2'd3;

  localparam int STAT_EN  = 0;
  localparam int STAT_OVF = 1;

  function automatic int addr_w(input int n);
    return $clog2(n) + 2;
  endfunction

endpackage

// File: rtl/wasca_perf_counter_if.sv
// Avalon-MM slave bus bundle for the performance counter.
// The master modport drives requests; the slave returns readdata.
interface wasca_perf_counter_if #(
  parameter int AW = 4
) ();

  logic [AW-1:0] address;
  logic          begintransfer;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, begintransfer, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, begintransfer, read, write, writedata,
    output readdata
  );

endinterface

// File: rtl/wasca_perf_counter_section.sv
// One profiling section: time/event counters, enable, sticky overflow
// and the high-half shadow used for coherent 64-bit reads.
module wasca_perf_counter_section
  import wasca_perf_counter_pkg::*;
#(
  parameter int TW = 64,
  parameter int EW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grst,
  input  logic          gen,
  input  logic          go,
  input  logic          stop,
  input  logic          clr_ovf,
  input  logic          snap,
  output logic [TW-1:0] cnt_q,
  output logic [EW-1:0] evt_q,
  output logic          en_q,
  output logic          ovf_q,
  output logic [TW-33:0] shadow_q
);

  logic run;
  logic start;
  logic wrap;

  assign run   = en_q & gen;
  assign start = go & gen;
  assign wrap  = run & (&cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      evt_q    <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
    end else if (grst) begin
      cnt_q <= '0;
      evt_q <= '0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + TW'(run);
      evt_q <= evt_q + EW'(start);
      // a wrap in the same cycle as a clear keeps the flag
      ovf_q <= wrap | (ovf_q & ~clr_ovf);
      if (stop)       en_q <= 1'b0;
      else if (start) en_q <= 1'b1;
      if (snap) shadow_q <= cnt_q[TW-1:32];
    end
  end

endmodule

// File: rtl/wasca_perf_counter_multi.sv
// Avalon-MM multi-section performance counter with shadowed 64-bit reads.
// WASCA_PERF_COUNTER_HW_TRIGGER_EN enables the hw_start/hw_stop inputs.
module wasca_perf_counter_multi
  import wasca_perf_counter_pkg::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter int TIME_WIDTH   = 64,
  parameter int EVENT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  wasca_perf_counter_if.slave     bus,
  input  logic [NUM_SECTIONS-1:0] hw_start,
  input  logic [NUM_SECTIONS-1:0] hw_stop
);

  localparam int NS = NUM_SECTIONS;

  logic [31:0] addr_x;
  logic [29:0] sec;
  logic [1:0]  ofs;
  logic        wr_stb;
  logic        rd_stb;
  logic        grst;
  logic        gen;
  logic        wd_unused;

  logic [NS-1:0] sw_go, sw_stop, clr, snap, go, stop;

  logic [TIME_WIDTH-1:0]  cnt    [NS];
  logic [EVENT_WIDTH-1:0] evt    [NS];
  logic [TIME_WIDTH-33:0] shadow [NS];
  logic                   en     [NS];
  logic                   ovf    [NS];
  logic [31:0]            mux;

  assign addr_x    = 32'(bus.address);
  assign sec       = addr_x[31:2];
  assign ofs       = addr_x[1:0];
  assign wr_stb    = bus.write & bus.begintransfer;
  assign rd_stb    = bus.read & bus.begintransfer;
  assign wd_unused = ^bus.writedata[31:2];

  assign grst = wr_stb & (ofs == OFS_TIME_LO) &
                (sec == '0) & bus.writedata[0];

  always_comb begin
    sw_go   = '0;
    sw_stop = '0;
    clr     = '0;
    snap    = '0;
    for (int s = 0; s < NS; s++) begin
      if (sec == 30'(s)) begin
        sw_stop[s] = wr_stb & (ofs == OFS_TIME_LO);
        sw_go[s]   = wr_stb & (ofs == OFS_TIME_HI);
        clr[s]     = wr_stb & (ofs == OFS_STATUS) &
                     bus.writedata[STAT_OVF];
        snap[s]    = rd_stb & (ofs == OFS_TIME_LO);
      end
    end
  end

`ifdef WASCA_PERF_COUNTER_HW_TRIGGER_EN
  assign go   = sw_go | hw_start;
  assign stop = sw_stop | hw_stop;
`else
  logic hw_unused;
  assign hw_unused = ^{hw_start, hw_stop};
  assign go   = sw_go;
  assign stop = sw_stop;
`endif

  // section 0 gates the whole block
  assign gen = en[0] | go[0];

  for (genvar g = 0; g < NS; g++) begin : g_sec
    wasca_perf_counter_section #(
      .TW (TIME_WIDTH),
      .EW (EVENT_WIDTH)
    ) u_sec (
      .clk      (clk),
      .reset    (reset),
      .grst     (grst),
      .gen      (gen),
      .go       (go[g]),
      .stop     (stop[g]),
      .clr_ovf  (clr[g]),
      .snap     (snap[g]),
      .cnt_q    (cnt[g]),
      .evt_q    (evt[g]),
      .en_q     (en[g]),
      .ovf_q    (ovf[g]),
      .shadow_q (shadow[g])
    );
  end

  always_comb begin
    mux = '0;
    for (int s = 0; s < NS; s++) begin
      if (sec == 30'(s)) begin
        unique case (ofs)
          OFS_TIME_LO: mux = cnt[s][31:0];
          OFS_TIME_HI: mux = 32'(shadow[s]);
          OFS_EVENT:   mux = 32'(evt[s]);
          default: begin
            mux[STAT_EN]  = en[s];
            mux[STAT_OVF] = ovf[s];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= mux;
  end

endmodule

// File: tb/tb_wasca_perf_counter_multi.sv
// Self-checking bench for wasca_perf_counter_multi: reference model,
// per-cycle readdata compare, directed literal cases and random traffic.
module tb_wasca_perf_counter_multi;
  import wasca_perf_counter_pkg::*;

  localparam int NS = 5;
  localparam int TW = 33;
  localparam int EW = 4;
  localparam int AW = addr_w(NS);
  localparam longint unsigned TMAX = (64'd1 << TW) - 64'd1;

`ifdef WASCA_PERF_COUNTER_HW_TRIGGER_EN
  localparam logic [31:0] HW_T = 32'd20;
  localparam logic [31:0] HW_E = 32'd1;
`else
  localparam logic [31:0] HW_T = 32'd0;
  localparam logic [31:0] HW_E = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NS-1:0] hw_start = '0;
  logic [NS-1:0] hw_stop = '0;
  logic [TW-1:0] poke_v = '0;

  wasca_perf_counter_if #(.AW(AW)) bus ();

  wasca_perf_counter_multi #(
    .NUM_SECTIONS (NS),
    .TIME_WIDTH   (TW),
    .EVENT_WIDTH  (EW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .hw_start (hw_start),
    .hw_stop  (hw_stop)
  );

  always #5 clk = ~clk;

  longint unsigned m_time [NS];
  longint unsigned m_sh   [NS];
  int unsigned     m_ev   [NS];
  bit              m_en   [NS];
  bit              m_ovf  [NS];
  logic [31:0]     exp_rd = '0;
  int total = 0;
  int bad = 0;

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_time[s] = 0; m_sh[s] = 0; m_ev[s] = 0;
      m_en[s] = 0; m_ovf[s] = 0;
    end
  endtask

  task automatic model_step();
    int unsigned a, sc, of;
    bit wr, rd, grst, gen, run, st;
    bit [NS-1:0] go, stp, clr;
    logic [31:0] wd;
    a  = 32'(bus.address);
    sc = a >> 2;
    of = a & 3;
    wr = bus.write && bus.begintransfer;
    rd = bus.read && bus.begintransfer;
    wd = bus.writedata;
    go = '0; stp = '0; clr = '0;
    if (wr && sc < NS) begin
      case (of)
        0: stp[sc] = 1'b1;
        1: go[sc] = 1'b1;
        3: clr[sc] = wd[1];
        default: ;
      endcase
    end
    grst = wr && sc == 0 && of == 0 && wd[0];
`ifdef WASCA_PERF_COUNTER_HW_TRIGGER_EN
    go  = go | hw_start;
    stp = stp | hw_stop;
`endif
    exp_rd = '0;
    if (sc < NS) begin
      case (of)
        0: exp_rd = 32'(m_time[sc]);
        1: exp_rd = 32'(m_sh[sc]);
        2: exp_rd = m_ev[sc];
        default: exp_rd = {30'd0, m_ovf[sc], m_en[sc]};
      endcase
      if (rd && of == 0) m_sh[sc] = m_time[sc] >> 32;
    end
    if (grst) begin
      for (int s = 0; s < NS; s++) begin
        m_time[s] = 0; m_ev[s] = 0; m_en[s] = 0; m_ovf[s] = 0;
      end
    end else begin
      gen = m_en[0] || go[0];
      for (int s = 0; s < NS; s++) begin
        run = m_en[s] && gen;
        st  = go[s] && gen;
        if (run && m_time[s] == TMAX) begin
          m_time[s] = 0;
          m_ovf[s] = 1;
        end else begin
          if (run) m_time[s] = m_time[s] + 1;
          if (clr[s]) m_ovf[s] = 0;
        end
        if (st) m_ev[s] = (m_ev[s] + 1) % (1 << EW);
        if (stp[s]) m_en[s] = 0;
        else if (st) m_en[s] = 1;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (reset) begin
        model_clear();
        exp_rd = '0;
      end else begin
        model_step();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    total++;
    if (bus.readdata !== exp_rd) begin
      bad++;
      $display("FAIL readdata @%0t: got %h want %h",
               $time, bus.readdata, exp_rd);
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // bus tasks are entered at a negedge and return at the next one
  task automatic wr(input int s, input int o, input logic [31:0] d);
    bus.address = AW'(s * 4 + o);
    bus.writedata = d;
    bus.write = 1'b1;
    bus.begintransfer = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    bus.begintransfer = 1'b0;
  endtask

  task automatic rd(input int s, input int o, output logic [31:0] q);
    bus.address = AW'(s * 4 + o);
    bus.read = 1'b1;
    bus.begintransfer = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    bus.begintransfer = 1'b0;
    q = bus.readdata;
  endtask

  task automatic poke0(input longint unsigned v);
    poke_v = TW'(v);
    force dut.g_sec[0].u_sec.cnt_q = poke_v;
    m_time[0] = v;
    @(negedge clk);
    @(negedge clk);
    release dut.g_sec[0].u_sec.cnt_q;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] q;

  initial begin
    bus.address = '0;
    bus.begintransfer = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.writedata = '0;
    repeat (3) @(negedge clk);
    chk("reset_readdata", bus.readdata, 32'd0);
    reset = 1'b0;
    idle(1);

    // go on 0, stop 10 cycles later
    wr(0, 1, 0);
    idle(9);
    wr(0, 0, 0);
    rd(0, 0, q); chk("s0_time_10", q, 32'd10);
    rd(0, 2, q); chk("s0_event_1", q, 32'd1);
    rd(0, 3, q); chk("s0_status_off", q, 32'd0);

    // section 1 alone cannot start
    wr(0, 0, 1);
    wr(1, 1, 0);
    idle(5);
    rd(1, 0, q); chk("s1_time_gated", q, 32'd0);
    rd(1, 2, q); chk("s1_event_gated", q, 32'd0);
    rd(1, 3, q); chk("s1_status_gated", q, 32'd0);

    // overflow wrap at 33 bits
    wr(0, 0, 1);
    poke0(TMAX);
    wr(0, 1, 0);
    idle(1);
    rd(0, 3, q); chk("ovf_status_11", q, 32'd3);
    wr(0, 3, 32'd2);
    rd(0, 3, q); chk("ovf_cleared_01", q, 32'd1);

    // wrap coincident with a clear keeps the flag
    wr(0, 0, 1);
    poke0(TMAX - 1);
    wr(0, 1, 0);
    idle(1);
    wr(0, 3, 32'd2);
    rd(0, 3, q); chk("ovf_wrap_vs_clear", q, 32'd3);

    // shadow coherence across the 32-bit boundary
    wr(0, 0, 1);
    poke0(64'hFFFF_FFFE);
    wr(0, 1, 0);
    idle(1);
    rd(0, 0, q); chk("shadow_lo", q, 32'hFFFF_FFFF);
    idle(5);
    rd(0, 1, q); chk("shadow_hi_0", q, 32'd0);
    rd(0, 0, q);
    rd(0, 1, q); chk("shadow_hi_1", q, 32'd1);

    // hardware triggers on section 2
    wr(0, 0, 1);
    wr(0, 1, 0);
    hw_start = NS'(1 << 2);
    @(negedge clk);
    hw_start = '0;
    idle(19);
    hw_stop = NS'(1 << 2);
    @(negedge clk);
    hw_stop = '0;
    idle(3);
    rd(2, 0, q); chk("hw_s2_time", q, HW_T);
    rd(2, 2, q); chk("hw_s2_event", q, HW_E);

    // global reset with everything running
    for (int s = 0; s < NS; s++) wr(s, 1, 0);
    idle(7);
    wr(0, 0, 1);
    for (int s = 0; s < NS; s++) begin
      rd(s, 0, q); chk($sformatf("grst_time%0d", s), q, 32'd0);
      rd(s, 2, q); chk($sformatf("grst_event%0d", s), q, 32'd0);
      rd(s, 3, q); chk($sformatf("grst_stat%0d", s), q, 32'd0);
    end

    // unmapped sections
    wr(0, 1, 0);
    wr(6, 1, 0);
    rd(5, 0, q); chk("unmapped5", q, 32'd0);
    rd(7, 3, q); chk("unmapped7", q, 32'd0);

    // randomized traffic near the wrap point
    wr(0, 0, 1);
    poke0(TMAX - 600);
    for (int i = 0; i < 3000; i++) begin
      int r, s, o;
      r = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7);
      o = $urandom_range(0, 3);
      bus.address = AW'(s * 4 + o);
      bus.writedata = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 15) == 0) bus.writedata[0] = 1'b1;
      hw_start = '0;
      hw_stop = '0;
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 19) == 0) hw_start[b] = 1'b1;
        if ($urandom_range(0, 24) == 0) hw_stop[b] = 1'b1;
      end
      bus.read = 1'b0;
      bus.write = 1'b0;
      bus.begintransfer = 1'b0;
      if (r < 35) begin
        bus.read = 1'b1; bus.begintransfer = 1'b1;
      end else if (r < 50) begin
        bus.address = AW'(s * 4 + 1);
        bus.write = 1'b1; bus.begintransfer = 1'b1;
      end else if (r < 58) begin
        bus.write = 1'b1; bus.begintransfer = 1'b1;
      end else if (r < 64) begin
        bus.read = 1'($urandom); bus.write = ~bus.read;
      end
      @(negedge clk);
    end
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.begintransfer = 1'b0;
    hw_start = '0;
    hw_stop = '0;

    // asynchronous reset mid-count
    wr(0, 1, 0);
    bus.address = AW'(0);
    idle(4);
    #1 reset = 1'b1;
    #1 chk("async_rst_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    rd(0, 0, q); chk("after_rst_time", q, 32'd0);
    rd(0, 3, q); chk("after_rst_status", q, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
